// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - two-stage pipelined adder/subtractor with valid/ready handshakes
//
// Purpose: computes s = a + (b ^ {WIDTH{sub}}) + (cin ^ sub) over two registered
// stages. Stage 1 sums the lower LO = WIDTH/2 bits. Stage 2 sums the upper half
// with the stage-1 carry and derives the flags. One result per clock when not stalled.
//
// Parameters:
//   WIDTH  operand/result width (even, >= 4)
//   TAG_W  sideband tag width (>= 1)
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          input handshake; in_ready is combinational from out_ready
//   a, b, sub, cin, in_tag     operation: sub=0 a+b+cin, sub=1 a-b-cin
//   out_valid/out_ready        output handshake; outputs hold while stalled
//   s, cout, overflow          result, carry out (sub: 1 = no borrow), signed overflow
//   zero, neg, out_tag         s == 0, s[MSB], tag travelling with the result
//
// Configuration macro: ADDSUB_PIPE_SAT_EN
//   When defined, s clamps to the signed max/min on overflow, and zero/neg follow
//   the clamped value. cout stays raw. Ports and latency are unchanged.

module addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  // Stage-1 holding register
  logic             s1_valid;
  logic [LO-1:0]    s1_lo;
  logic             s1_c;
  logic [HI-1:0]    s1_ahi;
  logic [HI-1:0]    s1_bhi;
  logic [TAG_W-1:0] s1_tag;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] bx;
  logic [LO:0]      lo_sum;
  logic [HI:0]      hi_sum;
  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_next;
  logic             ovf_next;

  // The output register may load when it is empty or being drained this cycle.
  // Stage 1 may load when it is empty or handing its entry to stage 2.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  always_comb begin
    bx     = b ^ {WIDTH{sub}};
    lo_sum = {1'b0, a[LO-1:0]} + {1'b0, bx[LO-1:0]} + {{LO{1'b0}}, cin ^ sub};
  end

  always_comb begin
    hi_sum   = {1'b0, s1_ahi} + {1'b0, s1_bhi} + {{HI{1'b0}}, s1_c};
    s_raw    = {hi_sum[HI-1:0], s1_lo};
    // Same-sign operands producing an opposite-sign result is signed overflow.
    ovf_next = (s1_ahi[HI-1] == s1_bhi[HI-1]) && (s_raw[WIDTH-1] != s1_ahi[HI-1]);
`ifdef ADDSUB_PIPE_SAT_EN
    if (ovf_next) begin
      // The overflow direction follows the sign of a: positive operands clamp high.
      s_next = s1_ahi[HI-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      s_next = s_raw;
    end
`else
    s_next = s_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_c      <= 1'b0;
      s1_ahi    <= '0;
      s1_bhi    <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_lo  <= lo_sum[LO-1:0];
          s1_c   <= lo_sum[LO];
          s1_ahi <= a[WIDTH-1:LO];
          s1_bhi <= bx[WIDTH-1:LO];
          s1_tag <= in_tag;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        // A bubble leaves the previous data in place; only out_valid drops.
        if (s1_valid) begin
          s        <= s_next;
          cout     <= hi_sum[HI];
          overflow <= ovf_next;
          zero     <= (s_next == '0);
          neg      <= s_next[WIDTH-1];
          out_tag  <= s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - self-checking bench for addsub_pipe against an arithmetic model

module tb_addsub_pipe;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int RV = W + 4 + TW;

  typedef logic [RV-1:0] res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          cin;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic          cout;
  logic          overflow;
  logic          zero;
  logic          neg;
  logic [TW-1:0] out_tag;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  res_t q[$];
  res_t prev_vec;
  bit   prev_stall = 0;

  addsub_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout),
    .overflow(overflow), .zero(zero), .neg(neg), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer arithmetic, then reduce to WIDTH bits.
  function automatic res_t model(input int av, input int bv, input bit sb, input bit cb, input int tg);
    int mx, sa, sbv, fu, fs, sv, tgv;
    bit co, ov, zr, ng;
    logic [W-1:0]  sl;
    logic [TW-1:0] tl;
    mx  = 1 << W;
    sa  = (av >= mx / 2) ? av - mx : av;
    sbv = (bv >= mx / 2) ? bv - mx : bv;
    if (!sb) begin
      fu = av + bv + int'(cb);
      fs = sa + sbv + int'(cb);
      co = (fu >= mx);
    end else begin
      fu = av - bv - int'(cb);
      fs = sa - sbv - int'(cb);
      co = (fu >= 0);
    end
    sv = ((fu % mx) + mx) % mx;
    ov = (fs > mx / 2 - 1) || (fs < -(mx / 2));
`ifdef ADDSUB_PIPE_SAT_EN
    if (ov) sv = (fs > 0) ? mx / 2 - 1 : mx / 2;
`endif
    zr  = (sv == 0);
    ng  = (sv >= mx / 2);
    tgv = tg;
    sl  = sv[W-1:0];
    tl  = tgv[TW-1:0];
    return {sl, co, ov, zr, ng, tl};
  endfunction

  function automatic res_t lit(input int sv, input bit co, input bit ov, input bit zr, input bit ng, input int tg);
    logic [W-1:0]  sl;
    logic [TW-1:0] tl;
    sl = sv[W-1:0];
    tl = tg[TW-1:0];
    return {sl, co, ov, zr, ng, tl};
  endfunction

  task automatic chk(input string name, input res_t act, input res_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // out_ready is changed at posedge+2 so mode changes made at posedge+1 apply the same cycle.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom % 4) != 0;
    endcase
  end

  // Compare process: the handshake values seen at negedge are the transfers of the next edge.
  always @(negedge clk) begin
    res_t cur;
    res_t exp;
    cur = {s, cout, overflow, zero, neg, out_tag};
    if (rst) begin
      q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || cur !== prev_vec) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b %h expected valid=1 %h", out_valid, cur, prev_vec);
        end
      end
      if (out_valid && q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_result: got valid=1 %h expected no result", cur);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        exp = q.pop_front();
        chk("result", cur, exp);
      end
      if (in_valid && in_ready) q.push_back(model(int'(a), int'(b), sub, cin, int'(in_tag)));
      prev_stall = out_valid && !out_ready;
      prev_vec   = cur;
    end
  end

  // Offer one operation and return just after the edge that accepts it.
  task automatic send(input int av, input int bv, input bit sb, input bit cb, input int tg);
    in_valid = 1'b1;
    a        = av[W-1:0];
    b        = bv[W-1:0];
    sub      = sb;
    cin      = cb;
    in_tag   = tg[TW-1:0];
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready=0 for 500 cycles expected acceptance");
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    checks++;
    if ({out_valid, s, cout, overflow, zero, neg, out_tag, in_ready} !== {1'b0, {(W+4+TW){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL %s: got valid=%b s=%h c=%b v=%b z=%b n=%b tag=%h in_ready=%b expected all 0 and in_ready=1",
               name, out_valid, s, cout, overflow, zero, neg, out_tag, in_ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; in_tag = '0;
    out_ready = 1'b0;

    // Model pinned by hand-computed results
    chk("model_100p27", model(100, 27, 0, 0, 0), lit(127, 0, 0, 0, 0, 0));
`ifdef ADDSUB_PIPE_SAT_EN
    chk("model_127p1", model(127, 1, 0, 0, 0), lit(8'h7F, 0, 1, 0, 0, 0));
`else
    chk("model_127p1", model(127, 1, 0, 0, 0), lit(8'h80, 0, 1, 0, 1, 0));
`endif
    chk("model_0m1", model(0, 1, 1, 0, 0), lit(8'hFF, 0, 0, 0, 1, 0));
    chk("model_5m5", model(5, 5, 1, 0, 3), lit(0, 1, 0, 1, 0, 3));
    chk("model_255p1c", model(255, 0, 0, 1, 0), lit(0, 1, 0, 1, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset_state");
    @(posedge clk);
    #1;

    // Latency: offered in cycle C, visible in cycle C+2
    ready_mode = 1;
    send(100, 27, 0, 0, 5);
    @(negedge clk);
    chk_bit("latency_c1_idle", out_valid, 1'b0);
    @(negedge clk);
    chk_bit("latency_c2_valid", out_valid, 1'b1);
    chk("direct_100p27", {s, cout, overflow, zero, neg, out_tag}, lit(127, 0, 0, 0, 0, 5));
    @(posedge clk);
    #1;

    send(127, 1, 0, 0, 1);
    send(0, 1, 1, 0, 2);
    send(5, 5, 1, 0, 3);
    repeat (4) @(posedge clk);
    #1;

    // Fill with out_ready low: two entries fit, the third is refused
    ready_mode = 0;
    send(1, 1, 0, 0, 1);
    send(2, 2, 0, 0, 2);
    in_valid = 1'b1; a = 3; b = 3; sub = 0; cin = 0; in_tag = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_bit("full_in_ready", in_ready, 1'b0);
      chk("full_tag_hold", {31'd0, out_valid, out_tag}, {31'd0, 1'b1, 4'd1});
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    @(negedge clk);
    chk_bit("release_in_ready", in_ready, 1'b1);
    chk("release_tag1", {31'd0, out_valid, out_tag}, {31'd0, 1'b1, 4'd1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_tag2", {31'd0, out_valid, out_tag}, {31'd0, 1'b1, 4'd2});
    @(negedge clk);
    chk("release_tag3", {31'd0, out_valid, out_tag}, {31'd0, 1'b1, 4'd3});
    @(posedge clk);
    #1;

    // Reset with two operations in flight
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(10, 20, 0, 0, 9);
    send(30, 40, 1, 1, 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("midstream_reset");
    ready_mode = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_bit("post_reset_idle", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Full rate: 100 back-to-back operations take 100 cycles
    t0 = cyc;
    for (int k = 0; k < 100; k++)
      send($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom), 1'($urandom), k);
    chk("full_rate_cycles", res_t'(cyc - t0), res_t'(100));

    // Corner operands at full rate
    begin
      int corner[5];
      corner = '{0, 1, 127, 128, 255};
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          for (int m = 0; m < 4; m++)
            send(corner[i], corner[j], m[1], m[0], i * 5 + j);
    end

    // Random operands, random back-pressure, occasional idle cycles
    ready_mode = 2;
    for (int k = 0; k < 3000; k++) begin
      if (($urandom % 5) == 0) begin
        @(posedge clk);
        #1;
      end
      send($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom), 1'($urandom), $urandom_range(0, 15));
    end

    // Drain
    ready_mode = 1;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", res_t'(q.size()), res_t'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
